// File: rtl/rv_enc_pkg.sv
// Shared RV32I/F encoding constants: request kinds, major opcodes and FP funct7 values.
// The core main decoder imports this same package so both sides stay bit-exact.
package rv_enc_pkg;

  localparam logic [3:0] KIND_RALU   = 4'd0;
  localparam logic [3:0] KIND_IALU   = 4'd1;
  localparam logic [3:0] KIND_LOAD   = 4'd2;
  localparam logic [3:0] KIND_STORE  = 4'd3;
  localparam logic [3:0] KIND_BRANCH = 4'd4;
  localparam logic [3:0] KIND_FADD   = 4'd5;
  localparam logic [3:0] KIND_FSUB   = 4'd6;
  localparam logic [3:0] KIND_FMUL   = 4'd7;
  localparam logic [3:0] KIND_FDIV   = 4'd8;
  localparam logic [3:0] KIND_FSQRT  = 4'd9;
  localparam logic [3:0] KIND_FLW    = 4'd10;
  localparam logic [3:0] KIND_FSW    = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_FADD   = 7'b0000000;
  localparam logic [6:0] F7_FSUB   = 7'b0000100;
  localparam logic [6:0] F7_FMUL   = 7'b0001000;
  localparam logic [6:0] F7_FDIV   = 7'b0001100;
  localparam logic [6:0] F7_FSQRT  = 7'b0101100;

  // FP loads/stores always move a 32-bit word
  localparam logic [2:0] F3_WORD   = 3'b010;

  typedef enum logic {ST_IDLE, ST_WRITE} wrState_e;

  function automatic logic kindLegal(input logic [3:0] kind);
    return kind <= KIND_FSW;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// DEPTH x WIDTH synchronous FIFO with a combinational head, full/empty flags and fill level.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         headData,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wrPtrReg;
  logic [PW:0]      rdPtrReg;
  logic             pushOk;
  logic             popOk;

  assign full     = (wrPtrReg[PW] != rdPtrReg[PW]) && (wrPtrReg[PW-1:0] == rdPtrReg[PW-1:0]);
  assign empty    = (wrPtrReg == rdPtrReg);
  assign level    = wrPtrReg - rdPtrReg;
  assign pushOk   = push && !full && !flush;
  assign popOk    = pop && !empty && !flush;
  assign headData = mem[rdPtrReg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (pushOk) begin
      mem[wrPtrReg[PW-1:0]] <= pushData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else if (flush) begin
      wrPtrReg <= '0;
      rdPtrReg <= '0;
    end else begin
      if (pushOk) wrPtrReg <= wrPtrReg + PTR_ONE;
      if (popOk)  rdPtrReg <= rdPtrReg + PTR_ONE;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into RV32I/F words, queues them and streams them
// into instruction memory at incrementing word addresses through a two-state write FSM.
module instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter int          IMEM_AW   = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_kind,
  input  logic [4:0]         req_rd,
  input  logic [4:0]         req_rs1,
  input  logic [4:0]         req_rs2,
  input  logic [2:0]         req_funct3,
  input  logic               req_alt,
  input  logic [12:0]        req_imm,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  input  logic               imem_ack,
  output logic [IMEM_AW:0]   wr_count,
  output logic               err
);

  localparam int LW = $clog2(DEPTH);
  localparam logic [IMEM_AW-1:0] BASE      = IMEM_AW'(BASE_ADDR);
  localparam logic [IMEM_AW-1:0] ADDR_ONE  = {{(IMEM_AW-1){1'b0}}, 1'b1};
  localparam logic [IMEM_AW:0]   COUNT_ONE = {{IMEM_AW{1'b0}}, 1'b1};
  localparam logic [LW:0]        LEVEL_ONE = {{LW{1'b0}}, 1'b1};

  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic        alt,
    input logic [12:0] imm
  );
    logic [31:0] word;
    word = '0;
    case (kind)
      KIND_RALU:   word = {(alt ? F7_ALT : F7_BASE), rs2, rs1, f3, rd, OP_R};
      KIND_IALU:   word = {imm[11:0], rs1, f3, rd, OP_I};
      KIND_LOAD:   word = {imm[11:0], rs1, f3, rd, OP_LOAD};
      KIND_STORE:  word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
      KIND_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
      KIND_FADD:   word = {F7_FADD, rs2, rs1, f3, rd, OP_FP};
      KIND_FSUB:   word = {F7_FSUB, rs2, rs1, f3, rd, OP_FP};
      KIND_FMUL:   word = {F7_FMUL, rs2, rs1, f3, rd, OP_FP};
      KIND_FDIV:   word = {F7_FDIV, rs2, rs1, f3, rd, OP_FP};
      // square root is unary: the rs2 field is architecturally zero
      KIND_FSQRT:  word = {F7_FSQRT, 5'd0, rs1, f3, rd, OP_FP};
      KIND_FLW:    word = {imm[11:0], rs1, F3_WORD, rd, OP_FLW};
      KIND_FSW:    word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_FSW};
      default:     word = '0;
    endcase
    return word;
  endfunction

  wrState_e           stateReg;
  wrState_e           stateNext;
  logic [IMEM_AW-1:0] addrReg;
  logic [IMEM_AW:0]   wrCountReg;
  logic               errReg;

  logic        accept;
  logic        legal;
  logic        push;
  logic        pop;
  logic [31:0] reqWord;
  logic [31:0] fifoHead;
  logic        fifoFull;
  logic        fifoEmpty;
  logic [LW:0] fifoLevel;

  assign req_ready = !fifoFull && !flush;
  assign accept    = req_valid && req_ready;
  assign legal     = kindLegal(req_kind);
  assign push      = accept && legal;
  assign reqWord   = encode(req_kind, req_rd, req_rs1, req_rs2, req_funct3, req_alt, req_imm);
  // an ack only counts while a write is actually being presented
  assign pop       = (stateReg == ST_WRITE) && imem_ack && !flush;

  enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .pushData (reqWord),
    .pop      (pop),
    .headData (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .level    (fifoLevel)
  );

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_IDLE:  if (!fifoEmpty) stateNext = ST_WRITE;
      // leave WRITE only when the last buffered word retires and nothing new arrives
      ST_WRITE: if (imem_ack && (fifoLevel == LEVEL_ONE) && !push) stateNext = ST_IDLE;
      default:  stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg   <= ST_IDLE;
      addrReg    <= BASE;
      wrCountReg <= '0;
      errReg     <= 1'b0;
    end else if (flush) begin
      stateReg   <= ST_IDLE;
      addrReg    <= BASE;
      wrCountReg <= '0;
      errReg     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      errReg   <= accept && !legal;
      if (pop) begin
        addrReg <= addrReg + ADDR_ONE;
        if (wrCountReg != '1) wrCountReg <= wrCountReg + COUNT_ONE;
      end
    end
  end

  assign imem_we    = (stateReg == ST_WRITE);
  assign imem_wdata = imem_we ? fifoHead : 32'd0;
  assign imem_addr  = addrReg;
  assign wr_count   = wrCountReg;
  assign err        = errReg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encodings, latency, back-pressure, address wrap,
// count saturation, illegal kinds, flush and asynchronous reset, checked through a scoreboard.
module tb_instr_encoder;
  import rv_enc_pkg::*;

  localparam int DEPTH   = 4;
  localparam int IMEM_AW = 2;
  localparam logic [IMEM_AW-1:0] BASE = 2'd1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flush = 1'b0;
  logic               reqValid = 1'b0;
  logic               reqReady;
  logic [3:0]         reqKind = '0;
  logic [4:0]         reqRd = '0;
  logic [4:0]         reqRs1 = '0;
  logic [4:0]         reqRs2 = '0;
  logic [2:0]         reqFunct3 = '0;
  logic               reqAlt = 1'b0;
  logic [12:0]        reqImm = '0;
  logic               imemWe;
  logic [IMEM_AW-1:0] imemAddr;
  logic [31:0]        imemWdata;
  logic               imemAck = 1'b0;
  logic [IMEM_AW:0]   wrCount;
  logic               err;

  instr_encoder #(
    .DEPTH     (DEPTH),
    .IMEM_AW   (IMEM_AW),
    .BASE_ADDR (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_kind   (reqKind),
    .req_rd     (reqRd),
    .req_rs1    (reqRs1),
    .req_rs2    (reqRs2),
    .req_funct3 (reqFunct3),
    .req_alt    (reqAlt),
    .req_imm    (reqImm),
    .imem_we    (imemWe),
    .imem_addr  (imemAddr),
    .imem_wdata (imemWdata),
    .imem_ack   (imemAck),
    .wr_count   (wrCount),
    .err        (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0]        expQ[$];
  logic [IMEM_AW-1:0] expAddr;
  logic [IMEM_AW:0]   expCount;
  logic [31:0]        curWord;
  logic               accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    expAddr  = BASE;
    expCount = '0;
  endtask

  // Called at a falling edge with inputs already driven; crosses one rising edge.
  task automatic tick();
    #1;
    accepted = reqValid && reqReady;
    if (imemWe && imemAck && !flush) begin
      check("pending_word", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        check("wdata", imemWdata, expQ.pop_front());
        check("addr", 32'(imemAddr), 32'(expAddr));
        $display("[TB] write addr=%0d data=0x%08h", imemAddr, imemWdata);
        expAddr++;
        if (expCount != '1) expCount++;
      end
    end
    if (accepted && reqKind <= KIND_FSW) expQ.push_back(curWord);
    @(negedge clk);
  endtask

  task automatic setReq(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                        input logic [12:0] imm, input logic [31:0] word);
    reqKind = k; reqRd = rd; reqRs1 = rs1; reqRs2 = rs2;
    reqFunct3 = f3; reqAlt = alt; reqImm = imm; curWord = word;
    reqValid = 1'b1;
  endtask

  task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic alt,
                      input logic [12:0] imm, input logic [31:0] word);
    setReq(k, rd, rs1, rs2, f3, alt, imm, word);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (accepted) break;
    end
    reqValid = 1'b0;
    check("accepted", 32'(accepted), 32'd1);
    $display("[TB] request kind=%0d expect=0x%08h accepted=%0b", k, word, accepted);
  endtask

  task automatic filler(input logic [4:0] rd, input logic [11:0] imm);
    send(KIND_IALU, rd, 5'd0, 5'd0, 3'd0, 1'b0, {1'b0, imm}, {imm, 5'd0, 3'd0, rd, 7'b0010011});
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || imemWe) && n < 40) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(expQ.size()), 32'd0);
    check("wr_count", 32'(wrCount), 32'(expCount));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    resetModel();
    accepted = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_we", 32'(imemWe), 32'd0);
    check("rst_addr", 32'(imemAddr), 32'(BASE));
    check("rst_wdata", imemWdata, 32'd0);
    check("rst_count", 32'(wrCount), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(reqReady), 32'd1);

    // accept -> write strobe two samples later
    send(KIND_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 13'd5, 32'h00500093);
    check("lat_we_first", 32'(imemWe), 32'd0);
    tick();
    check("lat_we_second", 32'(imemWe), 32'd1);
    check("lat_wdata", imemWdata, 32'h00500093);
    check("lat_addr", 32'(imemAddr), 32'(BASE));
    imemAck = 1'b1;
    drain();

    // encoding vectors, streamed with ack held high (wraps address, saturates count)
    send(KIND_FADD,   5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'd0,      32'h002081D3);
    send(KIND_FSQRT,  5'd4, 5'd5, 5'd7, 3'd0, 1'b0, 13'd0,      32'h58028253);
    send(KIND_STORE,  5'd9, 5'd2, 5'd5, 3'd2, 1'b0, 13'd8,      32'h00512423);
    send(KIND_BRANCH, 5'd9, 5'd1, 5'd2, 3'd0, 1'b0, 13'd16,     32'h00208863);
    send(KIND_RALU,   5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 13'h0FFF,   32'h402081B3);
    send(KIND_FLW,    5'd2, 5'd3, 5'd0, 3'd0, 1'b0, 13'd4,      32'h0041A107);
    send(KIND_FSW,    5'd9, 5'd3, 5'd2, 3'd0, 1'b0, 13'd8,      32'h0021A427);
    send(KIND_FMUL,   5'd1, 5'd2, 5'd3, 3'd7, 1'b0, 13'd0,      32'h103170D3);
    send(KIND_BRANCH, 5'd9, 5'd1, 5'd2, 3'd1, 1'b0, 13'h1FF8,   32'hFE209CE3);
    send(KIND_LOAD,   5'd5, 5'd2, 5'd0, 3'd2, 1'b0, 13'h1FFC,   32'hFFC12283);
    drain();
    check("count_saturated", 32'(wrCount), 32'd7);

    // flush while idle clears address and count
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_count", 32'(wrCount), 32'd0);
    check("flush_addr", 32'(imemAddr), 32'(BASE));
    resetModel();

    // back-pressure: four accepts fill the FIFO, fifth waits
    imemAck = 1'b0;
    filler(5'd1, 12'h011);
    filler(5'd2, 12'h012);
    filler(5'd3, 12'h013);
    filler(5'd4, 12'h014);
    check("full_ready", 32'(reqReady), 32'd0);
    setReq(KIND_IALU, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 13'h015, {12'h015, 5'd0, 3'd0, 5'd5, 7'b0010011});
    repeat (3) tick();
    check("full_hold", 32'(expQ.size()), 32'd4);
    imemAck = 1'b1;
    #1;
    check("no_bypass", 32'(reqReady), 32'd0);
    filler(5'd5, 12'h015);
    drain();

    // illegal kind: accepted, one-cycle err, nothing written
    send(4'd13, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 13'd1, 32'd0);
    check("err_pulse", 32'(err), 32'd1);
    tick();
    check("err_clear", 32'(err), 32'd0);
    check("err_no_write", 32'(imemWe), 32'd0);
    check("err_count", 32'(wrCount), 32'(expCount));

    // flush with a write in flight and an ack in the same cycle
    imemAck = 1'b0;
    filler(5'd6, 12'h021);
    filler(5'd7, 12'h022);
    filler(5'd8, 12'h023);
    check("pre_flush_we", 32'(imemWe), 32'd1);
    flush = 1'b1;
    imemAck = 1'b1;
    #1;
    check("flush_ready", 32'(reqReady), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    imemAck = 1'b0;
    check("flush_we", 32'(imemWe), 32'd0);
    check("flush_count2", 32'(wrCount), 32'd0);
    check("flush_addr2", 32'(imemAddr), 32'(BASE));
    resetModel();
    imemAck = 1'b1;
    filler(5'd10, 12'h031);
    drain();

    // asynchronous reset mid-write
    imemAck = 1'b0;
    filler(5'd11, 12'h041);
    filler(5'd12, 12'h042);
    check("pre_rst_we", 32'(imemWe), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_we", 32'(imemWe), 32'd0);
    check("arst_addr", 32'(imemAddr), 32'(BASE));
    check("arst_count", 32'(wrCount), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    resetModel();
    @(negedge clk);
    imemAck = 1'b1;
    filler(5'd13, 12'h051);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
